ktms_debug_trig_ctl: RTL

- MMIO-programmed trigger/capture sequencer for the debug capture-history shift register (rega/regb history, depth cr_depth).
- Generates the history shift enable: arm, pre-fill, trigger on a masked event, count post-trigger captures, freeze.
- Reports state and counters through an MMIO status read.
- Sits beside the debug register block; its o_cap_en replaces the raw miss strobe on the history latch enable.

---
 rtl/ktms_debug_trig_ctl_pkg.sv | 31 +++
 rtl/capi_mmio_reg.sv | 34 +++
 rtl/ktms_debug_trig_ctl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ktms_debug_trig_ctl_pkg.sv
// rtl/ktms_debug_trig_ctl_pkg.sv - shared encodings and field offsets for the debug trigger controller
package ktms_debug_trig_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } trig_state_t;

  localparam int CTL_ARM    = 0;
  localparam int CTL_DISARM = 1;
  localparam int CTL_MODE   = 2;
  localparam int CTL_MASK   = 8;
  localparam int CTL_POST   = 16;
  localparam int CTL_PRE    = 32;

  localparam int STS_STATE  = 0;
  localparam int STS_TRIG   = 2;
  localparam int STS_SNAP   = 8;
  localparam int STS_REM    = 16;
  localparam int STS_FILL   = 32;
  localparam int STS_CAPT   = 48;

  localparam int STS_ADDR_OFS = 1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] lim);
    return (v >= lim) ? lim : v + 16'd1;
  endfunction

endpackage

// File: rtl/capi_mmio_reg.sv
// rtl/capi_mmio_reg.sv - MMIO request decode for a control register and its companion status register
module capi_mmio_reg #(
  parameter int mmiobus_width = 92,
  parameter int mmioaddr      = 1,
  parameter int sts_ofs       = 1
) (
  input  logic [mmiobus_width-1:0] mmiobus,
  output logic                     wr_v,
  output logic [63:0]              wr_d,
  output logic [1:0]               rd_v
);

  localparam logic [23:0] CTL_A = 24'(mmioaddr);
  localparam logic [23:0] STS_A = 24'(mmioaddr + sts_ofs);

  logic        vld;
  logic        cfg;
  logic        rnw;
  logic        dw;
  logic [23:0] addr;
  logic [63:0] data;
  logic        req;
  logic        unused_dw;

  assign {vld, cfg, rnw, dw, addr, data} = mmiobus[91:0];
  assign unused_dw = dw;

  // config-space cycles belong to another decoder
  assign req  = vld & ~cfg;
  assign wr_v = req & ~rnw & (addr == CTL_A);
  assign wr_d = data;
  assign rd_v = {req & rnw & (addr == STS_A), req & rnw & (addr == CTL_A)};

endmodule

// File: rtl/ktms_debug_trig_ctl.sv
// rtl/ktms_debug_trig_ctl.sv - arm/pre-fill/trigger/post-count sequencer driving the capture-history shift enable
module ktms_debug_trig_ctl #(
  parameter int n_evt         = 8,
  parameter int cr_depth      = 16,
  parameter int mmioaddr      = 1,
  parameter int mmiobus_width = 92
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [mmiobus_width-1:0] i_mmiobus,
  input  logic [n_evt-1:0]         i_evt,
  input  logic                     i_smp,
  output logic                     o_cap_en,
  output logic                     o_trig_v,
  output logic                     o_frozen,
  output logic                     o_mmio_rd_v,
  output logic [63:0]              o_mmio_rd_d
);

  import ktms_debug_trig_ctl_pkg::*;

  localparam logic [15:0] DEPTH     = 16'(cr_depth);
  localparam logic [7:0]  EVT_VALID = 8'((9'd1 << n_evt) - 9'd1);

  logic        wr_v;
  logic [63:0] wr_d;
  logic [1:0]  rd_sel;
  logic        arm_w;
  logic        disarm_w;
  logic        unused_wr;

  trig_state_t state;
  trig_state_t state_nxt;
  logic        mode;
  logic [7:0]  evt_mask;
  logic [15:0] post_cnt;
  logic [15:0] pre_min;
  logic [15:0] fill;
  logic [15:0] remaining;
  logic [7:0]  snapshot;
  logic [15:0] cap_total;
  logic        triggered;

  logic [7:0]  evt8;
  logic [15:0] pre_eff;
  logic        cap;
  logic        trig;
  logic [63:0] ctl_rb;
  logic [63:0] sts_rb;

  capi_mmio_reg #(
    .mmiobus_width(mmiobus_width),
    .mmioaddr     (mmioaddr),
    .sts_ofs      (STS_ADDR_OFS)
  ) u_mmio (
    .mmiobus(i_mmiobus),
    .wr_v   (wr_v),
    .wr_d   (wr_d),
    .rd_v   (rd_sel)
  );

  assign arm_w     = wr_v & wr_d[CTL_ARM];
  assign disarm_w  = wr_v & wr_d[CTL_DISARM];
  assign unused_wr = ^{wr_d[63:48], wr_d[7:3]};

  assign evt8    = 8'(i_evt);
  assign pre_eff = (pre_min < DEPTH) ? pre_min : DEPTH;

  always_comb begin
    state_nxt = state;
    trig      = 1'b0;
    cap       = ((state == ST_PRE) || (state == ST_POST)) && (mode ? i_smp : 1'b1);
    if (disarm_w) begin
      state_nxt = ST_IDLE;
    end else if (arm_w) begin
      state_nxt = ST_PRE;
    end else begin
      case (state)
        ST_PRE: begin
          if ((|(evt8 & evt_mask)) && (fill >= pre_eff)) begin
            trig      = 1'b1;
            state_nxt = (post_cnt == 16'd0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (cap && (remaining == 16'd1)) state_nxt = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode      <= 1'b0;
      evt_mask  <= 8'd0;
      post_cnt  <= 16'd0;
      pre_min   <= 16'd0;
      fill      <= 16'd0;
      remaining <= 16'd0;
      snapshot  <= 8'd0;
      cap_total <= 16'd0;
      triggered <= 1'b0;
    end else if (arm_w) begin
      mode      <= wr_d[CTL_MODE];
      evt_mask  <= wr_d[CTL_MASK +: 8] & EVT_VALID;
      post_cnt  <= wr_d[CTL_POST +: 16];
      pre_min   <= wr_d[CTL_PRE +: 16];
      fill      <= 16'd0;
      remaining <= 16'd0;
      snapshot  <= 8'd0;
      cap_total <= 16'd0;
      triggered <= 1'b0;
    end else if (!disarm_w) begin
      if (cap) begin
        fill      <= sat_inc(fill, DEPTH);
        cap_total <= sat_inc(cap_total, 16'hFFFF);
      end
      // the capture on the trigger cycle itself is not charged to post_cnt
      if (trig) begin
        remaining <= post_cnt;
        snapshot  <= evt8 & evt_mask;
        triggered <= 1'b1;
      end else if ((state == ST_POST) && cap) begin
        remaining <= remaining - 16'd1;
      end
    end
  end

  always_comb begin
    ctl_rb                  = '0;
    ctl_rb[CTL_MODE]        = mode;
    ctl_rb[CTL_MASK +: 8]   = evt_mask;
    ctl_rb[CTL_POST +: 16]  = post_cnt;
    ctl_rb[CTL_PRE +: 16]   = pre_min;
    sts_rb                  = '0;
    sts_rb[STS_STATE +: 2]  = state;
    sts_rb[STS_TRIG]        = triggered;
    sts_rb[STS_SNAP +: 8]   = snapshot;
    sts_rb[STS_REM +: 16]   = remaining;
    sts_rb[STS_FILL +: 16]  = fill;
    sts_rb[STS_CAPT +: 16]  = cap_total;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_mmio_rd_v <= 1'b0;
      o_mmio_rd_d <= 64'd0;
    end else begin
      o_mmio_rd_v <= |rd_sel;
      if (|rd_sel) o_mmio_rd_d <= rd_sel[1] ? sts_rb : ctl_rb;
    end
  end

  assign o_cap_en = cap;
  assign o_trig_v = trig;
  assign o_frozen = (state == ST_DONE);

endmodule
